window_addr_gen: RTL and testbench

//  Parametrised sliding-window read-address generator feeding the semi-systolic array.
//  It scans a WIN x WIN window across an IMG_W x IMG_H row-major frame held in the line/frame RAM.

---
 rtl/window_addr_gen.sv | 161 ++++++++++++++++
 tb/tb_window_addr_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/window_addr_gen.sv
// window_addr_gen: sliding-window RAM read-address generator with full and column-reuse scan modes
module window_addr_gen #(
    parameter int IMG_W  = 50,
    parameter int IMG_H  = 50,
    parameter int WIN    = 3,
    parameter int STRIDE = 1,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              reuse_mode,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] read_select,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [2:0]        tap_row,
    output logic [2:0]        tap_col,
    output logic              window_last,
    output logic              scan_start,
    output logic              frame_done,
    output logic              busy
);
    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);
    localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_W    = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] A_ROW  = ADDR_W'(STRIDE * IMG_W);
    localparam logic [ADDR_W-1:0] A_S    = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] A_WM1  = ADDR_W'(WIN - 1);
    localparam logic [2:0]        T_LAST = 3'(WIN - 1);
    localparam logic [2:0]        J_REU  = 3'(WIN - STRIDE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_n;
    logic              reuse_q, reuse_n;
    logic [RW-1:0]     r_q, r_n;
    logic [CW-1:0]     c_q, c_n;
    logic [2:0]        t_n, j_n;
    logic [ADDR_W-1:0] rb_q, rb_n, col_q, col_n, addr_n;
    logic              valid_n, wl_n, scan_n, done_n, busy_n;
    logic              beat, t_end, j_end, c_more, r_more;

    // rb_q tracks the top-left of the current window row, col_q the top of the current tap column
    always_comb begin
        beat    = addr_valid && addr_ready;
        t_end   = tap_row == T_LAST;
        j_end   = tap_col == T_LAST;
        c_more  = int'(c_q) + STRIDE <= IMG_W - WIN;
        r_more  = int'(r_q) + STRIDE <= IMG_H - WIN;
        state_n = state;
        reuse_n = reuse_q;
        r_n     = r_q;
        c_n     = c_q;
        t_n     = tap_row;
        j_n     = tap_col;
        rb_n    = rb_q;
        col_n   = col_q;
        addr_n  = read_select;
        valid_n = addr_valid;
        wl_n    = window_last;
        scan_n  = scan_start;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            IDLE: if (start && !abort) begin
                state_n = RUN;
                reuse_n = reuse_mode;
                r_n     = '0;
                c_n     = '0;
                t_n     = '0;
                j_n     = '0;
                rb_n    = base_addr;
                col_n   = base_addr;
                addr_n  = base_addr;
                valid_n = 1'b1;
                busy_n  = 1'b1;
                scan_n  = 1'b0;
                wl_n    = 1'b0;
            end
            RUN: if (abort) begin
                state_n = IDLE;
                valid_n = 1'b0;
                busy_n  = 1'b0;
                scan_n  = 1'b0;
                wl_n    = 1'b0;
            end else if (beat) begin
                scan_n = scan_start | window_last;
                if (!t_end) begin
                    t_n    = tap_row + 3'd1;
                    addr_n = read_select + A_W;
                end else if (!j_end) begin
                    t_n    = '0;
                    j_n    = tap_col + 3'd1;
                    col_n  = col_q + A_ONE;
                    addr_n = col_q + A_ONE;
                end else if (c_more) begin
                    // in reuse the next window resumes right after the column just emitted
                    t_n    = '0;
                    c_n    = c_q + CW'(STRIDE);
                    j_n    = reuse_q ? J_REU : 3'd0;
                    col_n  = reuse_q ? col_q + A_ONE : col_q + A_S - A_WM1;
                    addr_n = reuse_q ? col_q + A_ONE : col_q + A_S - A_WM1;
                end else if (r_more) begin
                    t_n    = '0;
                    j_n    = '0;
                    c_n    = '0;
                    r_n    = r_q + RW'(STRIDE);
                    rb_n   = rb_q + A_ROW;
                    col_n  = rb_q + A_ROW;
                    addr_n = rb_q + A_ROW;
                end else begin
                    state_n = DONE;
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                    scan_n  = 1'b0;
                    done_n  = 1'b1;
                end
                wl_n = (state_n == RUN) && (t_n == T_LAST) && (j_n == T_LAST);
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            reuse_q     <= 1'b0;
            r_q         <= '0;
            c_q         <= '0;
            tap_row     <= '0;
            tap_col     <= '0;
            rb_q        <= '0;
            col_q       <= '0;
            read_select <= '0;
            addr_valid  <= 1'b0;
            window_last <= 1'b0;
            scan_start  <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            reuse_q     <= reuse_n;
            r_q         <= r_n;
            c_q         <= c_n;
            tap_row     <= t_n;
            tap_col     <= j_n;
            rb_q        <= rb_n;
            col_q       <= col_n;
            read_select <= addr_n;
            addr_valid  <= valid_n;
            window_last <= wl_n;
            scan_start  <= scan_n;
            frame_done  <= done_n;
            busy        <= busy_n;
        end
    end
endmodule

// File: tb/tb_window_addr_gen.sv
// tb_window_addr_gen: randomized check of window_addr_gen against a loop-nest model of the scan
module tb_window_addr_gen;
    localparam int W = 5, H = 4, WN = 3, AW = 14;

    logic          clk = 0, rst = 0, start = 0, start2 = 0, abort = 0, reuse_mode = 0, addr_ready = 1;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] read_select, read_select2;
    logic          addr_valid, window_last, scan_start, frame_done, busy;
    logic          addr_valid2, window_last2, scan_start2, frame_done2, busy2;
    logic [2:0]    tap_row, tap_col, tap_row2, tap_col2;

    window_addr_gen #(.IMG_W(W), .IMG_H(H), .WIN(WN), .STRIDE(1), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .reuse_mode(reuse_mode),
        .base_addr(base_addr), .read_select(read_select), .addr_valid(addr_valid),
        .addr_ready(addr_ready), .tap_row(tap_row), .tap_col(tap_col),
        .window_last(window_last), .scan_start(scan_start), .frame_done(frame_done), .busy(busy));

    window_addr_gen #(.IMG_W(W), .IMG_H(H), .WIN(WN), .STRIDE(2), .ADDR_W(AW)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort), .reuse_mode(reuse_mode),
        .base_addr(base_addr), .read_select(read_select2), .addr_valid(addr_valid2),
        .addr_ready(addr_ready), .tap_row(tap_row2), .tap_col(tap_col2),
        .window_last(window_last2), .scan_start(scan_start2), .frame_done(frame_done2), .busy(busy2));

    always #5 clk = ~clk;

    int errors = 0, checks = 0, beats = 0;
    int q_a[$], q_t[$], q_j[$], q_w[$];
    int m_a[$], m_t[$], m_j[$], m_w[$];
    bit m_run = 0, m_scan = 0, m_done = 0;
    int m_idx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // expected beat list straight from the scan rules: rows, windows, columns, taps
    function automatic void build(input bit reuse, input int s, input int base);
        q_a.delete(); q_t.delete(); q_j.delete(); q_w.delete();
        for (int r = 0; r <= H - WN; r += s)
            for (int c = 0; c <= W - WN; c += s)
                for (int j = (reuse && c > 0) ? WN - s : 0; j < WN; j++)
                    for (int t = 0; t < WN; t++) begin
                        q_a.push_back((base + (r + t) * W + c + j) % (1 << AW));
                        q_t.push_back(t);
                        q_j.push_back(j);
                        q_w.push_back((t == WN - 1 && j == WN - 1) ? 1 : 0);
                    end
    endfunction

    always @(negedge clk) begin
        bit nd;
        if (!rst) begin
            m_run = 0; m_scan = 0; m_done = 0;
        end
        chk("valid", addr_valid, m_run);
        chk("busy", busy, m_run);
        chk("scan_start", scan_start, m_scan);
        chk("frame_done", frame_done, m_done);
        if (m_run) begin
            if (m_idx < m_a.size()) begin
                chk("addr", read_select, m_a[m_idx]);
                chk("tap_row", tap_row, m_t[m_idx]);
                chk("tap_col", tap_col, m_j[m_idx]);
                chk("window_last", window_last, m_w[m_idx]);
            end else chk("beat_overrun", m_idx, m_a.size() - 1);
        end
        if (rst) begin
            if (addr_valid && addr_ready) beats++;
            nd = 0;
            if (!m_run) begin
                if (!m_done && start && !abort) begin
                    build(reuse_mode, 1, int'(base_addr));
                    m_a = q_a; m_t = q_t; m_j = q_j; m_w = q_w;
                    m_idx = 0; m_run = 1; m_scan = 0;
                end
            end else if (abort) begin
                m_run = 0; m_scan = 0;
            end else if (addr_ready) begin
                if (m_w[m_idx] != 0) m_scan = 1;
                m_idx++;
                if (m_idx >= m_a.size()) begin
                    m_run = 0; m_scan = 0; nd = 1;
                end
            end
            m_done = nd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit reuse, input int base, input bit bp, input bit spam, input int exp_beats);
        int n;
        reuse_mode = reuse; base_addr = AW'(base); addr_ready = 1; beats = 0;
        start = 1;
        tick();
        start = 0;
        n = 0;
        while (!frame_done && n < 3000) begin
            if (bp) begin
                addr_ready = 1'($urandom % 2);
                reuse_mode = 1'($urandom % 2);
                base_addr  = AW'($urandom_range(0, 1000));
            end
            if (spam) start = ($urandom % 3 == 0);
            tick();
            n++;
        end
        start = 0; addr_ready = 1;
        chk("frame_timeout", frame_done, 1);
        chk("beat_count", beats, exp_beats);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int full12[12] = '{0, 5, 10, 1, 6, 11, 2, 7, 12, 1, 6, 11};
        int reu15[15]  = '{0, 5, 10, 1, 6, 11, 2, 7, 12, 3, 8, 13, 4, 9, 14};
        int s2[15]     = '{100, 105, 110, 101, 106, 111, 102, 107, 112, 103, 108, 113, 104, 109, 114};
        int n;
        build(0, 1, 0);
        chk("model_full_len", q_a.size(), 54);
        for (int i = 0; i < 12; i++) chk("model_full_addr", q_a[i], full12[i]);
        chk("model_full_last", q_a[53], 19);
        build(1, 1, 0);
        chk("model_reuse_len", q_a.size(), 30);
        for (int i = 0; i < 15; i++) chk("model_reuse_addr", q_a[i], reu15[i]);
        chk("model_reuse_wl9", q_w[8], 1);
        chk("model_reuse_wl10", q_w[9], 0);
        chk("model_reuse_wl12", q_w[11], 1);

        repeat (3) tick();
        rst = 1;
        tick();

        run_frame(0, 0, 0, 0, 54);
        tick();
        run_frame(1, 0, 0, 0, 30);
        tick();
        run_frame(0, 0, 1, 0, 54);
        tick();
        run_frame(1, 37, 1, 0, 30);
        tick();

        reuse_mode = 0; base_addr = '0; beats = 0;
        start = 1;
        tick();
        start = 0;
        n = 0;
        while (beats < 20 && n < 200) begin tick(); n++; end
        abort = 1; start = 1;
        tick();
        abort = 0; start = 0;
        repeat (3) tick();
        chk("abort_busy", busy, 0);
        start = 1; abort = 1;
        tick();
        start = 0; abort = 0;
        tick();
        chk("abort_beats_start", addr_valid, 0);
        run_frame(0, 0, 0, 0, 54);
        tick();

        start = 1;
        tick();
        start = 0;
        repeat (10) tick();
        #1 rst = 0;
        #1 chk("rst_async", {read_select, addr_valid, tap_row, tap_col, window_last, scan_start, frame_done, busy}, 0);
        repeat (2) tick();
        rst = 1;
        tick();
        run_frame(0, 0, 0, 1, 54);
        tick();

        build(1, 2, 100);
        chk("model_s2_len", q_a.size(), 15);
        for (int i = 0; i < 15; i++) chk("model_s2_addr", q_a[i], s2[i]);
        reuse_mode = 1; base_addr = AW'(100); addr_ready = 1;
        start2 = 1;
        tick();
        start2 = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("s2_valid", addr_valid2, 1);
            chk("s2_addr", read_select2, q_a[i]);
        end
        @(negedge clk);
        chk("s2_frame_done", frame_done2, 1);
        chk("s2_valid_end", addr_valid2, 0);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
